// File: rtl/systolic_mm_stream_pkg.sv
// systolic_pkg: FSM encoding and width helpers shared by the systolic matrix engine.
package systolic_pkg;
    localparam logic [1:0] S_IDLE = 2'd0, S_FEED = 2'd1, S_FLUSH = 2'd2, S_DRAIN = 2'd3;
    function automatic int o_bits_of(input int i_bits, input int k_max);
        return 2 * i_bits + $clog2(k_max);
    endfunction
    function automatic int clog2_min1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/systolic_mm_stream_if.sv
// systolic_mm_stream_if: operand stream in, result-row stream out, job control and status.
interface systolic_mm_stream_if import systolic_pkg::*; #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int I_BITS = 8,
    parameter int K_MAX = 16,
    parameter int O_BITS = o_bits_of(I_BITS, K_MAX),
    parameter int KW = $clog2(K_MAX + 1),
    parameter int IW = clog2_min1(ROWS)
);
    logic                   i_start;
    logic [KW-1:0]          i_k_len;
    logic [ROWS*I_BITS-1:0] i_a_col;
    logic [COLS*I_BITS-1:0] i_b_row;
    logic                   i_valid;
    logic                   o_ready;
    logic [COLS*O_BITS-1:0] o_c_row;
    logic [IW-1:0]          o_c_idx;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_last;
    logic                   o_busy;
    logic                   o_err;
    modport master (
        output i_start, i_k_len, i_a_col, i_b_row, i_valid, i_ready,
        input  o_ready, o_c_row, o_c_idx, o_valid, o_last, o_busy, o_err
    );
    modport slave (
        input  i_start, i_k_len, i_a_col, i_b_row, i_valid, i_ready,
        output o_ready, o_c_row, o_c_idx, o_valid, o_last, o_busy, o_err
    );
endinterface

// File: rtl/systolic_mm_stream_pe.sv
// systolic_mac_pe: one output-stationary MAC cell; forwards a right and b down through one register each.
module systolic_mac_pe #(
    parameter int I_BITS = 8,
    parameter int O_BITS = 20,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [I_BITS-1:0] a_in,
    input  logic [I_BITS-1:0] b_in,
    output logic [I_BITS-1:0] a_out,
    output logic [I_BITS-1:0] b_out,
    output logic [O_BITS-1:0] acc
);
    localparam int P = 2 * I_BITS;
    logic [P-1:0] a_x, b_x, prod;
    logic [O_BITS-1:0] prod_x;
    // Extending operands to full product width makes one unsigned multiply serve both modes.
    assign a_x = {{I_BITS{SIGNED != 0 && a_in[I_BITS-1]}}, a_in};
    assign b_x = {{I_BITS{SIGNED != 0 && b_in[I_BITS-1]}}, b_in};
    assign prod = a_x * b_x;
    assign prod_x = {{(O_BITS-P){SIGNED != 0 && prod[P-1]}}, prod};
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            a_out <= '0;
            b_out <= '0;
            acc <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc <= acc + prod_x;
        end
    end
endmodule

// File: rtl/systolic_mm_stream.sv
// systolic_mm_stream: ROWS x COLS output-stationary matrix multiply with internal skew,
// stall-transparent operand stream and row-serial result drain.
module systolic_mm_stream import systolic_pkg::*; #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int I_BITS = 8,
    parameter int K_MAX = 16,
    parameter int SIGNED = 1,
    parameter int O_BITS = o_bits_of(I_BITS, K_MAX)
) (
    input logic i_clock,
    input logic i_reset,
    systolic_mm_stream_if.slave bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int IW = clog2_min1(ROWS);
    localparam int FW = clog2_min1(ROWS + COLS);
    logic [1:0] state;
    logic [KW-1:0] k_q, beat;
    logic [FW-1:0] fl;
    logic [IW-1:0] idx;
    logic err_q, start_ok, clr, feed, en;
    logic [I_BITS-1:0] a_h [ROWS][COLS];
    logic [I_BITS-1:0] a_o [ROWS][COLS];
    logic [I_BITS-1:0] b_v [ROWS][COLS];
    logic [I_BITS-1:0] b_o [ROWS][COLS];
    logic [O_BITS-1:0] acc [ROWS][COLS];
    assign start_ok = bus.i_k_len != '0 && bus.i_k_len <= KW'(K_MAX);
    assign clr = state == S_IDLE && bus.i_start && start_ok;
    assign feed = state == S_FEED && bus.i_valid;
    assign en = feed || state == S_FLUSH;
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= S_IDLE;
            k_q <= '0;
            beat <= '0;
            fl <= '0;
            idx <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= state == S_IDLE && bus.i_start && !start_ok;
            case (state)
                S_IDLE: if (clr) begin
                    k_q <= bus.i_k_len;
                    beat <= '0;
                    state <= S_FEED;
                end
                S_FEED: if (feed) begin
                    beat <= beat + KW'(1);
                    fl <= '0;
                    if (beat + KW'(1) == k_q) state <= ROWS + COLS == 2 ? S_DRAIN : S_FLUSH;
                end
                S_FLUSH: begin
                    fl <= fl + FW'(1);
                    if (fl == FW'(ROWS + COLS - 3)) state <= S_DRAIN;
                end
                default: if (bus.i_ready) begin
                    idx <= idx == IW'(ROWS - 1) ? '0 : idx + IW'(1);
                    if (idx == IW'(ROWS - 1)) state <= S_IDLE;
                end
            endcase
        end
    end
    assign bus.o_ready = state == S_FEED;
    assign bus.o_valid = state == S_DRAIN;
    assign bus.o_busy = state != S_IDLE;
    assign bus.o_err = err_q;
    assign bus.o_c_idx = idx;
    assign bus.o_last = bus.o_valid && idx == IW'(ROWS - 1);
    // Row r of A waits r enables so every operand pair meets in PE(r,c) at enable r+c.
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        logic [I_BITS-1:0] a_src;
        assign a_src = feed ? bus.i_a_col[r*I_BITS +: I_BITS] : '0;
        if (r == 0) begin : g_direct
            assign a_h[r][0] = a_src;
        end else begin : g_delay
            logic [I_BITS-1:0] d [r];
            always_ff @(posedge i_clock) begin
                if (i_reset || clr) begin
                    for (int i = 0; i < r; i++) d[i] <= '0;
                end else if (en) begin
                    d[0] <= a_src;
                    for (int i = 1; i < r; i++) d[i] <= d[i-1];
                end
            end
            assign a_h[r][0] = d[r-1];
        end
    end
    for (genvar c = 0; c < COLS; c++) begin : g_bskew
        logic [I_BITS-1:0] b_src;
        assign b_src = feed ? bus.i_b_row[c*I_BITS +: I_BITS] : '0;
        if (c == 0) begin : g_direct
            assign b_v[0][c] = b_src;
        end else begin : g_delay
            logic [I_BITS-1:0] d [c];
            always_ff @(posedge i_clock) begin
                if (i_reset || clr) begin
                    for (int i = 0; i < c; i++) d[i] <= '0;
                end else if (en) begin
                    d[0] <= b_src;
                    for (int i = 1; i < c; i++) d[i] <= d[i-1];
                end
            end
            assign b_v[0][c] = d[c-1];
        end
    end
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c > 0) begin : g_afwd
                assign a_h[r][c] = a_o[r][c-1];
            end
            if (r > 0) begin : g_bfwd
                assign b_v[r][c] = b_o[r-1][c];
            end
            systolic_mac_pe #(.I_BITS(I_BITS), .O_BITS(O_BITS), .SIGNED(SIGNED)) u_pe (
                .clk(i_clock), .rst(i_reset), .en(en), .clr(clr),
                .a_in(a_h[r][c]), .b_in(b_v[r][c]),
                .a_out(a_o[r][c]), .b_out(b_o[r][c]), .acc(acc[r][c])
            );
        end
    end
    for (genvar c = 0; c < COLS; c++) begin : g_out
        assign bus.o_c_row[c*O_BITS +: O_BITS] = bus.o_valid ? acc[idx][c] : '0;
    end
endmodule

// File: tb/tb_systolic_mm_stream.sv
// tb_systolic_mm_stream: directed checks of a signed and an unsigned 4x4 engine driven in lockstep.
module tb_systolic_mm_stream;
    localparam int ROWS = 4, COLS = 4, I_BITS = 8, K_MAX = 16, O_BITS = 20;
    logic clk = 1'b0;
    logic rst;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    systolic_mm_stream_if #(.ROWS(ROWS), .COLS(COLS), .I_BITS(I_BITS), .K_MAX(K_MAX)) bus_s ();
    systolic_mm_stream_if #(.ROWS(ROWS), .COLS(COLS), .I_BITS(I_BITS), .K_MAX(K_MAX)) bus_u ();
    assign bus_u.i_start = bus_s.i_start;
    assign bus_u.i_k_len = bus_s.i_k_len;
    assign bus_u.i_a_col = bus_s.i_a_col;
    assign bus_u.i_b_row = bus_s.i_b_row;
    assign bus_u.i_valid = bus_s.i_valid;
    assign bus_u.i_ready = bus_s.i_ready;
    systolic_mm_stream #(.ROWS(ROWS), .COLS(COLS), .I_BITS(I_BITS), .K_MAX(K_MAX), .SIGNED(1)) u_s (
        .i_clock(clk), .i_reset(rst), .bus(bus_s)
    );
    systolic_mm_stream #(.ROWS(ROWS), .COLS(COLS), .I_BITS(I_BITS), .K_MAX(K_MAX), .SIGNED(0)) u_u (
        .i_clock(clk), .i_reset(rst), .bus(bus_u)
    );
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    // mode 0: A=I so C=B; 1: all -128; 2: all 255 (signed sees -1); 3: 2*3 with K=1
    function automatic logic [79:0] exp_row(input int mode, input int r, input bit uns);
        logic [79:0] v;
        int e;
        for (int c = 0; c < COLS; c++) begin
            e = mode == 0 ? 4*r + c + 1 : mode == 1 ? 262144 : mode == 2 ? (uns ? 1040400 : 16) : 6;
            v[c*O_BITS +: O_BITS] = 20'(e);
        end
        return v;
    endfunction
    function automatic logic [31:0] id_a(input int k);
        return 32'h1 << (8*k);
    endfunction
    function automatic logic [31:0] id_b(input int k);
        return {8'(4*k + 4), 8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1)};
    endfunction
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask
    task automatic start(input int k);
        bus_s.i_start = 1'b1;
        bus_s.i_k_len = 5'(k);
        cyc;
        bus_s.i_start = 1'b0;
    endtask
    task automatic beat(input logic [31:0] a, input logic [31:0] b);
        bus_s.i_a_col = a;
        bus_s.i_b_row = b;
        bus_s.i_valid = 1'b1;
        cyc;
        bus_s.i_valid = 1'b0;
        bus_s.i_a_col = 32'hA5A5A5A5;
        bus_s.i_b_row = 32'h5A5A5A5A;
    endtask
    task automatic gap;
        bus_s.i_valid = 1'b0;
        cyc;
    endtask
    task automatic wait_valid(input int exp_lat);
        int n = 1;
        while (!bus_s.o_valid && n < 40) begin
            cyc;
            n++;
        end
        chk("first_valid_latency", 128'(n), 128'(exp_lat));
    endtask
    task automatic drain(input int mode, input int hold_row);
        for (int r = 0; r < ROWS; r++) begin
            if (r == hold_row) begin
                bus_s.i_ready = 1'b0;
                repeat (3) begin
                    cyc;
                    chk("hold_row", 128'(bus_s.o_c_row), 128'(exp_row(mode, r, 0)));
                    chk("hold_idx", 128'(bus_s.o_c_idx), 128'(r));
                end
            end
            bus_s.i_ready = 1'b1;
            chk("row_valid", 128'(bus_s.o_valid), 128'(1));
            chk("row_idx", 128'(bus_s.o_c_idx), 128'(r));
            chk("row_signed", 128'(bus_s.o_c_row), 128'(exp_row(mode, r, 0)));
            chk("row_unsigned", 128'(bus_u.o_c_row), 128'(exp_row(mode, r, 1)));
            chk("row_last", 128'(bus_s.o_last), 128'(r == ROWS - 1));
            cyc;
        end
        bus_s.i_ready = 1'b0;
        chk("idle_after_drain", 128'(bus_s.o_busy), 128'(0));
        chk("valid_after_drain", 128'(bus_s.o_valid), 128'(0));
    endtask
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 128'(bus_s.o_ready), 128'(0));
        chk({tag, "_valid"}, 128'(bus_s.o_valid), 128'(0));
        chk({tag, "_last"}, 128'(bus_s.o_last), 128'(0));
        chk({tag, "_busy"}, 128'(bus_s.o_busy | bus_u.o_busy), 128'(0));
        chk({tag, "_err"}, 128'(bus_s.o_err), 128'(0));
        chk({tag, "_row"}, 128'(bus_s.o_c_row), 128'(0));
        chk({tag, "_idx"}, 128'(bus_s.o_c_idx), 128'(0));
    endtask
    initial begin
        rst = 1'b1;
        bus_s.i_start = 1'b0;
        bus_s.i_k_len = '0;
        bus_s.i_a_col = '0;
        bus_s.i_b_row = '0;
        bus_s.i_valid = 1'b0;
        bus_s.i_ready = 1'b0;
        cyc;
        cyc;
        check_reset_outputs("reset");
        rst = 1'b0;
        cyc;
        // identity A, streaming without gaps
        start(4);
        chk("feed_busy", 128'(bus_s.o_busy), 128'(1));
        chk("feed_ready", 128'(bus_s.o_ready), 128'(1));
        for (int k = 0; k < 4; k++) beat(id_a(k), id_b(k));
        chk("flush_not_ready", 128'(bus_s.o_ready), 128'(0));
        wait_valid(7);
        drain(0, -1);
        // all -128 operands
        start(16);
        for (int k = 0; k < 16; k++) beat({4{8'h80}}, {4{8'h80}});
        wait_valid(7);
        drain(1, -1);
        // all 255 operands
        start(16);
        for (int k = 0; k < 16; k++) beat({4{8'hFF}}, {4{8'hFF}});
        wait_valid(7);
        drain(2, -1);
        // input gaps every other cycle, output backpressure on row 1
        start(4);
        for (int k = 0; k < 4; k++) begin
            gap;
            beat(id_a(k), id_b(k));
        end
        wait_valid(7);
        drain(0, 1);
        // rejected starts
        start(0);
        chk("k0_err", 128'(bus_s.o_err), 128'(1));
        chk("k0_busy", 128'(bus_s.o_busy), 128'(0));
        cyc;
        chk("k0_err_pulse", 128'(bus_s.o_err), 128'(0));
        start(17);
        chk("k17_err", 128'(bus_s.o_err), 128'(1));
        chk("k17_busy", 128'(bus_s.o_busy), 128'(0));
        cyc;
        chk("k17_err_pulse", 128'(bus_s.o_err), 128'(0));
        // start pulsed mid-job must be ignored
        start(4);
        beat(id_a(0), id_b(0));
        beat(id_a(1), id_b(1));
        start(1);
        chk("midjob_err", 128'(bus_s.o_err), 128'(0));
        chk("midjob_ready", 128'(bus_s.o_ready), 128'(1));
        beat(id_a(2), id_b(2));
        beat(id_a(3), id_b(3));
        wait_valid(7);
        drain(0, -1);
        // reset mid-job, then a fresh K=1 job
        start(4);
        beat({4{8'h7F}}, {4{8'h7F}});
        beat({4{8'h7F}}, {4{8'h7F}});
        rst = 1'b1;
        cyc;
        check_reset_outputs("midreset");
        rst = 1'b0;
        start(1);
        beat({4{8'h02}}, {4{8'h03}});
        wait_valid(7);
        drain(3, -1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
